reg_access_ctrl: RTL

REG_ACCESS_CTRL -- requirements
Module: reg_access_ctrl

---
 rtl/reg_access_pkg.sv | 22 ++
 rtl/reg_access_sweep.sv | 50 +++++
 rtl/reg_access_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/reg_access_pkg.sv
// Shared types and constants for the register-file access controller.
// Optional feature macro: REG_ACCESS_SWEEP_EN (adds the power-on clearing sweep state).
package reg_access_pkg;

    localparam int REG_ADDR_W_DEF = 5;
    localparam int REG_DATA_W_DEF = 32;

    // Index of the hard-wired zero register; writes to it are rejected.
    localparam int X0_IDX = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_RESP  = 3'd3
`ifdef REG_ACCESS_SWEEP_EN
        ,
        ST_SWEEP = 3'd4
`endif
    } state_e;

endpackage

// File: rtl/reg_access_sweep.sv
// Power-on sweep sequencer: walks indices 1..(2**REG_ADDR_W-1) one per cycle
// so the controller can clear every writable register after reset.
// Only instantiated when REG_ACCESS_SWEEP_EN is defined.
module reg_access_sweep
    import reg_access_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  sweep_we,
    output logic [REG_ADDR_W-1:0] sweep_idx,
    output logic                  sweep_last
);

    localparam logic [REG_ADDR_W-1:0] FIRST_IDX = REG_ADDR_W'(1);
    localparam logic [REG_ADDR_W-1:0] LAST_IDX  = '1;

    logic                  active_q, active_d;
    logic [REG_ADDR_W-1:0] idx_q, idx_d;

    // Advance the index while active; hold at the last index instead of wrapping.
    always_comb begin
        active_d = active_q;
        idx_d    = idx_q;
        if (active_q) begin
            if (idx_q == LAST_IDX) begin
                active_d = 1'b0;
            end else begin
                idx_d = idx_q + REG_ADDR_W'(1);
            end
        end
    end

    // Reset restarts the sweep at index 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b1;
            idx_q    <= FIRST_IDX;
        end else begin
            active_q <= active_d;
            idx_q    <= idx_d;
        end
    end

    assign sweep_we   = active_q;
    assign sweep_idx  = idx_q;
    assign sweep_last = active_q && (idx_q == LAST_IDX);

endmodule

// File: rtl/reg_access_ctrl.sv
// Register-file access controller: single-outstanding valid/ready request
// port translated into one-cycle register-file write or dual-read accesses,
// with a held response until consumed. Writes to index 0 are rejected.
// Optional feature macro: REG_ACCESS_SWEEP_EN (clears indices 1..31 after reset).
module reg_access_ctrl
    import reg_access_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int REG_DATA_W = REG_DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    // request side
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [REG_ADDR_W-1:0] req_addr1,
    input  logic [REG_ADDR_W-1:0] req_addr2,
    input  logic [REG_DATA_W-1:0] req_wdata,
    // response side
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_err,
    output logic [REG_DATA_W-1:0] rsp_rdata1,
    output logic [REG_DATA_W-1:0] rsp_rdata2,
    // register-file side
    output logic                  RegWEn,
    output logic [REG_ADDR_W-1:0] WriteReg,
    output logic [REG_DATA_W-1:0] RegWriteData,
    output logic [REG_ADDR_W-1:0] ReadReg1,
    output logic [REG_ADDR_W-1:0] ReadReg2,
    input  logic [REG_DATA_W-1:0] RegReadData1,
    input  logic [REG_DATA_W-1:0] RegReadData2
);

    localparam logic [REG_ADDR_W-1:0] ZERO_IDX = REG_ADDR_W'(X0_IDX);

`ifdef REG_ACCESS_SWEEP_EN
    localparam state_e RESET_STATE = ST_SWEEP;
`else
    localparam state_e RESET_STATE = ST_IDLE;
`endif

    state_e                state_q, state_d;
    logic                  regwen_q, regwen_d;
    logic [REG_ADDR_W-1:0] writereg_q, writereg_d;
    logic [REG_DATA_W-1:0] wdata_q, wdata_d;
    logic [REG_ADDR_W-1:0] readreg1_q, readreg1_d;
    logic [REG_ADDR_W-1:0] readreg2_q, readreg2_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [REG_DATA_W-1:0] rdata1_q, rdata1_d;
    logic [REG_DATA_W-1:0] rdata2_q, rdata2_d;

`ifdef REG_ACCESS_SWEEP_EN
    logic                  sweep_we;
    logic [REG_ADDR_W-1:0] sweep_idx;
    logic                  sweep_last;
    logic                  sweep_on;

    reg_access_sweep #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_sweep (
        .clk        (clk),
        .rst        (rst),
        .sweep_we   (sweep_we),
        .sweep_idx  (sweep_idx),
        .sweep_last (sweep_last)
    );

    // The sweep drives the write port directly; masked by rst so the
    // register-file side sits at zero while reset is held.
    assign sweep_on = sweep_we && (state_q == ST_SWEEP) && !rst;
`endif

    // Next-state and next-output computation for the request/response FSM.
    always_comb begin
        state_d     = state_q;
        regwen_d    = 1'b0;
        writereg_d  = writereg_q;
        wdata_d     = wdata_q;
        readreg1_d  = readreg1_q;
        readreg2_d  = readreg2_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rdata1_d    = rdata1_q;
        rdata2_d    = rdata2_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_wr) begin
                        if (req_addr1 == ZERO_IDX) begin
                            // Rejected write: skip the register file entirely.
                            state_d     = ST_RESP;
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = 1'b1;
                        end else begin
                            state_d    = ST_WRITE;
                            regwen_d   = 1'b1;
                            writereg_d = req_addr1;
                            wdata_d    = req_wdata;
                        end
                    end else begin
                        state_d    = ST_READ;
                        readreg1_d = req_addr1;
                        readreg2_d = req_addr2;
                    end
                end
            end
            ST_WRITE: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
            end
            ST_READ: begin
                // Register-file read data is combinational off ReadReg1/2.
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rdata1_d    = RegReadData1;
                rdata2_d    = RegReadData2;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
`ifdef REG_ACCESS_SWEEP_EN
            ST_SWEEP: begin
                if (sweep_last) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RESET_STATE;
            regwen_q    <= 1'b0;
            writereg_q  <= '0;
            wdata_q     <= '0;
            readreg1_q  <= '0;
            readreg2_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata1_q    <= '0;
            rdata2_q    <= '0;
        end else begin
            state_q     <= state_d;
            regwen_q    <= regwen_d;
            writereg_q  <= writereg_d;
            wdata_q     <= wdata_d;
            readreg1_q  <= readreg1_d;
            readreg2_q  <= readreg2_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rdata1_q    <= rdata1_d;
            rdata2_q    <= rdata2_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE) && !rst;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_rdata1 = rdata1_q;
    assign rsp_rdata2 = rdata2_q;
    assign ReadReg1   = readreg1_q;
    assign ReadReg2   = readreg2_q;

`ifdef REG_ACCESS_SWEEP_EN
    assign RegWEn       = regwen_q || sweep_on;
    assign WriteReg     = sweep_on ? sweep_idx : writereg_q;
    assign RegWriteData = sweep_on ? '0 : wdata_q;
`else
    assign RegWEn       = regwen_q;
    assign WriteReg     = writereg_q;
    assign RegWriteData = wdata_q;
`endif

endmodule
